// File: rtl/ufo_saucer_pkg.sv
// Shared types and constants for the UFO saucer controller.
// Sprite geometry and the bonus table sit here so the renderer can import the same values.
package ufo_saucer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLY     = 2'd1,
    ST_EXPLODE = 2'd2
  } ufo_state_e;

  localparam int unsigned UFO_SCREEN_W = 640;
  localparam int unsigned UFO_SPRITE_W = 16;
  localparam int unsigned UFO_ROW_Y    = 40;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned EXPL_W  = 8;

  function automatic logic [6:0] bonus_value(input logic [1:0] sel);
    logic [6:0] pts;
    case (sel)
      2'b00:   pts = 7'd5;
      2'b01:   pts = 7'd10;
      2'b10:   pts = 7'd15;
      default: pts = 7'd30;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/ufo_saucer_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free running, reusable for missile timing.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting form: polynomial taps 16,14,13,11 land on bits 0,2,3,5.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign lfsr_o = lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/ufo_saucer.sv
// Mystery-ship controller: random spawn delay, one horizontal pass per spawn,
// hit detection with a one-cycle bonus pulse and a frame-counted explosion hold.
module ufo_saucer
  import ufo_saucer_pkg::*;
#(
  parameter int unsigned SCREEN_W       = UFO_SCREEN_W,
  parameter int unsigned UFO_W          = UFO_SPRITE_W,
  parameter int unsigned UFO_Y          = UFO_ROW_Y,
  parameter int unsigned UFO_SPEED      = 2,
  parameter int unsigned SPAWN_MIN      = 256,
  parameter logic [7:0]  SPAWN_MASK     = 8'hFF,
  parameter int unsigned EXPLODE_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arst,
  input  logic       frame,
  input  logic       ufo_hit,
  input  logic       done,
  output logic       ufo_active,
  output logic       ufo_exploding,
  output logic [9:0] ufo_x,
  output logic [9:0] ufo_y,
  output logic       bonus_valid,
  output logic [6:0] bonus_points
);

  localparam logic [10:0]        X_MAX11   = 11'(SCREEN_W - UFO_W);
  localparam logic [10:0]        STEP11    = 11'(UFO_SPEED);
  localparam logic [POS_W-1:0]   X_MAX     = POS_W'(SCREEN_W - UFO_W);
  localparam logic [POS_W-1:0]   STEP      = POS_W'(UFO_SPEED);
  localparam logic [TIMER_W-1:0] TIMER_MIN = TIMER_W'(SPAWN_MIN);
  localparam logic [EXPL_W-1:0]  EXPL_INIT = EXPL_W'(EXPLODE_FRAMES);

  logic              rst_any;
  logic [15:0]       lfsr;
  logic [TIMER_W-1:0] reload;
  logic [10:0]       x_ext;

  ufo_state_e        state_q, state_d;
  logic              dir_left_q, dir_left_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [EXPL_W-1:0] expl_cnt_q, expl_cnt_d;
  logic [POS_W-1:0]  x_q, x_d;
  logic              active_q, active_d;
  logic              exploding_q, exploding_d;
  logic              bonus_valid_q, bonus_valid_d;
  logic [6:0]        bonus_points_q, bonus_points_d;

  assign rst_any = rst | arst;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst_any),
    .lfsr_o (lfsr)
  );

  assign reload = TIMER_MIN + {8'd0, lfsr[7:0] & SPAWN_MASK};
  // Widened so the rightward exit test cannot wrap near the 10-bit limit.
  assign x_ext  = {1'b0, x_q};

  always_comb begin
    state_d        = state_q;
    dir_left_d     = dir_left_q;
    timer_d        = timer_q;
    expl_cnt_d     = expl_cnt_q;
    x_d            = x_q;
    active_d       = active_q;
    exploding_d    = exploding_q;
    bonus_valid_d  = 1'b0;
    bonus_points_d = bonus_points_q;

    case (state_q)
      ST_IDLE: begin
        if (frame) begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (!done) begin
            state_d  = ST_FLY;
            active_d = 1'b1;
            x_d      = dir_left_q ? X_MAX : '0;
          end
        end
      end

      ST_FLY: begin
        if (done) begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
          x_d      = '0;
        end else if (ufo_hit) begin
          state_d        = ST_EXPLODE;
          active_d       = 1'b0;
          exploding_d    = 1'b1;
          expl_cnt_d     = EXPL_INIT;
          bonus_valid_d  = 1'b1;
          bonus_points_d = bonus_value(lfsr[1:0]);
        end else if (frame) begin
          if ((!dir_left_q && (x_ext + STEP11 > X_MAX11)) ||
              ( dir_left_q && (x_ext < STEP11))) begin
            state_d    = ST_IDLE;
            active_d   = 1'b0;
            dir_left_d = ~dir_left_q;
            timer_d    = reload;
          end else begin
            x_d = dir_left_q ? (x_q - STEP) : (x_q + STEP);
          end
        end
      end

      ST_EXPLODE: begin
        if (frame) begin
          // Leave on the frame that takes the counter to zero.
          if (expl_cnt_q <= EXPL_W'(1)) begin
            state_d     = ST_IDLE;
            exploding_d = 1'b0;
            expl_cnt_d  = '0;
            dir_left_d  = ~dir_left_q;
            timer_d     = reload;
          end else begin
            expl_cnt_d = expl_cnt_q - 1'b1;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        active_d    = 1'b0;
        exploding_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state_q        <= ST_IDLE;
      dir_left_q     <= 1'b0;
      timer_q        <= TIMER_MIN;
      expl_cnt_q     <= '0;
      x_q            <= '0;
      active_q       <= 1'b0;
      exploding_q    <= 1'b0;
      bonus_valid_q  <= 1'b0;
      bonus_points_q <= '0;
    end else begin
      state_q        <= state_d;
      dir_left_q     <= dir_left_d;
      timer_q        <= timer_d;
      expl_cnt_q     <= expl_cnt_d;
      x_q            <= x_d;
      active_q       <= active_d;
      exploding_q    <= exploding_d;
      bonus_valid_q  <= bonus_valid_d;
      bonus_points_q <= bonus_points_d;
    end
  end

  assign ufo_active    = active_q;
  assign ufo_exploding = exploding_q;
  assign ufo_x         = x_q;
  assign ufo_y         = POS_W'(UFO_Y);
  assign bonus_valid   = bonus_valid_q;
  assign bonus_points  = bonus_points_q;

endmodule
